usr_deserializer: RTL and testbench
===================================

# usr_deserializer

Serial-to-parallel receiver for the universal shift register family. It accepts a qualified serial bit stream, either MSB-first or LSB-first, and assembles SIZE-bit words. Completed words go to a one-entry output register with a valid/ready handshake. It sits at the far end of a serial link driven by a parallel-loaded shift register: shift-left mode emits bit SIZE-1 first, and shift-right mode emits bit 0 first.

## Interface
- SIZE, 4, word width in bits; legal range SIZE >= 2.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- dir  input  1  bit order: 0 = MSB-first (shift-left source), 1 = LSB-first (shift-right source); sampled with the first bit of each word.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is valid this cycle; one bit accepted per cycle when high.
- flush  input  1  discard the partially assembled word; output register unaffected.
- clr_ovr  input  1  clear the sticky overrun flag.
- pout  output  SIZE  assembled word; stable while pout_valid && !pout_ready.
- pout_valid  output  1  pout holds an unconsumed word.
- pout_ready  input  1  consumer accepts pout this cycle.
- overrun  output  1  sticky: a completed word was dropped because the output register was full.
- busy  output  1  a partial word is in progress (bit count != 0).

## Operation
- Internal state:
  - shift register sr[SIZE-1:0]
  - bit counter cnt, 0..SIZE-1, width clog2(SIZE) (min 1)
  - latched order bit ord
  - output register pout, with flag pout_valid
- Collector FSM:
  - IDLE (cnt=0): on sin_valid, latch ord<=dir, take first bit, cnt<=1, go to SHIFT.
  - SHIFT: each sin_valid takes one bit and increments cnt.
  - On the bit that makes SIZE bits, return to IDLE with cnt<=0 and produce word w.
- Bit placement:
  - ord=0: sr <= {sr[SIZE-2:0], sin}. The first bit received ends up at w[SIZE-1].
  - ord=1: sr <= {sin, sr[SIZE-1:1]}. The first bit received ends up at w[0].
- w is formed from the next-state value of sr, so it includes the final bit.
- dir changes mid-word are ignored until the next word starts.
- Gaps (sin_valid low) hold all collector state indefinitely.
- Word completion:
  - If pout_valid=0, or pout_valid && pout_ready in the same cycle: pout<=w, pout_valid<=1.
  - Otherwise w is dropped, overrun<=1, and pout is unchanged.
- Consumption without completion: pout_valid && pout_ready sets pout_valid<=0; pout keeps its last value.
- flush: cnt<=0, FSM to IDLE, sr<=0.
  - A sin_valid in the same cycle is ignored; flush wins.
  - pout, pout_valid and overrun are untouched.
- clr_ovr: overrun<=0. If a drop happens in the same cycle, set wins and overrun stays 1.
- rst (any cycle, including mid-word or with pout_valid=1):
  - sr=0, cnt=0, FSM to IDLE, ord=0.
  - pout=0, pout_valid=0, overrun=0, busy=0.
  - Reset has priority over all other inputs.

## Timing
- Fully synchronous; no combinational path from inputs to outputs.
- Latency: a final bit accepted at edge t makes pout/pout_valid visible after edge t, i.e. usable in cycle t+1.
- Throughput: one bit per cycle sustained. Back-to-back words need no idle cycle: the first bit of word k+1 may be presented the cycle after the last bit of word k.
- Handshake:
  - The transfer occurs at the edge where pout_valid && pout_ready.
  - pout_ready while pout_valid=0 has no effect.
  - pout_valid never drops without a transfer or rst.
- A minimum-length word occupies SIZE accepting cycles. Consumption frees the output register in the same edge, so a consumer holding pout_ready=1 never causes overrun.
- busy = (cnt != 0), registered.

## Test plan
- MSB-first: SIZE=4, rst then dir=0, bits 1,0,1,1 on 4 consecutive cycles, pout_ready=1 → pout=4'b1011, pout_valid high exactly one cycle after the 4th bit, busy low.
- LSB-first with gaps: dir=1, bits 1,0,1,1 with sin_valid low for 2 cycles between bits 2 and 3, dir toggled mid-word → pout=4'b1101.
- Backpressure/overrun: pout_ready=0, send words 4'hA then 4'h5 MSB-first → pout stays 4'hA, overrun=1. Then pout_ready=1 for one cycle → pout_valid=0. Then clr_ovr → overrun=0.
- Simultaneous completion and consumption: word 4'h3 pending, pout_ready=1 on the same cycle as the last bit of 4'hC → pout=4'hC, pout_valid stays 1, overrun=0.
- Flush: 2 bits sent, flush with sin_valid=1, then 4 bits 0,1,1,0 MSB-first → pout=4'h6. A pending pout before the flush is preserved.
- Reset mid-operation: 3 bits sent with pout_valid=1 → rst → pout=0, pout_valid=0, overrun=0, busy=0. Next 4 bits form a clean word.

Source files
------------

// File: rtl/usr_deserializer_if.sv
// Bundle of serial-in, parallel-out and status signals for usr_deserializer.
// slave is the deserializer's view; master is the bit source / word consumer.
interface usr_deserializer_if #(
  parameter int SIZE = 4
);
  logic            dir;
  logic            sin;
  logic            sin_valid;
  logic            flush;
  logic            clr_ovr;
  logic [SIZE-1:0] pout;
  logic            pout_valid;
  logic            pout_ready;
  logic            overrun;
  logic            busy;

  modport slave (
    input  dir,
    input  sin,
    input  sin_valid,
    input  flush,
    input  clr_ovr,
    input  pout_ready,
    output pout,
    output pout_valid,
    output overrun,
    output busy
  );

  modport master (
    output dir,
    output sin,
    output sin_valid,
    output flush,
    output clr_ovr,
    output pout_ready,
    input  pout,
    input  pout_valid,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/usr_deserializer.sv
// Serial-to-parallel word assembler: one bit per cycle, word visible the cycle after its last bit.
// One-entry valid/ready output; a word completing into a full register is dropped and sets overrun.
module usr_deserializer #(
  parameter int SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  usr_deserializer_if.slave   bus
);

  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ord_q, ord_d;
  logic [SIZE-1:0] pout_q, pout_d;
  logic            pout_valid_q, pout_valid_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;

  logic            bit_ord;
  logic [SIZE-1:0] sr_shifted;
  logic            word_done;
  logic            consume;
  logic            drop;

  // Order for the bit being taken now: a fresh word uses dir directly.
  always_comb begin
    bit_ord = (state_q == IDLE) ? bus.dir : ord_q;
    if (bit_ord) begin
      sr_shifted = {bus.sin, sr_q[SIZE-1:1]};
    end else begin
      sr_shifted = {sr_q[SIZE-2:0], bus.sin};
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ord_d     = ord_q;
    word_done = 1'b0;

    if (bus.flush) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else if (bus.sin_valid) begin
      sr_d = sr_shifted;
      case (state_q)
        IDLE: begin
          ord_d   = bus.dir;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Consumption frees the register on the same edge, so completion may refill it.
  always_comb begin
    pout_d       = pout_q;
    pout_valid_d = pout_valid_q;
    consume      = pout_valid_q && bus.pout_ready;
    drop         = 1'b0;

    if (word_done) begin
      if (!pout_valid_q || bus.pout_ready) begin
        pout_d       = sr_shifted;
        pout_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (consume) begin
      pout_valid_d = 1'b0;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      ord_q        <= 1'b0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      ord_q        <= ord_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = pout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_usr_deserializer.sv
// Bench for usr_deserializer: directed scenarios plus a randomized run against a bit-queue model.
module tb_usr_deserializer;
  localparam int SIZE = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  usr_deserializer_if #(.SIZE(SIZE)) bus ();

  usr_deserializer #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: received bits of the current word kept in arrival order.
  bit              mq[$];
  bit              m_ord;
  logic [SIZE-1:0] m_pout;
  bit              m_pv;
  bit              m_ovr;

  task automatic step();
    bit              done;
    bit              ovr_set;
    logic [SIZE-1:0] w;
    done    = 0;
    ovr_set = 0;
    w       = '0;
    if (rst) begin
      mq.delete();
      m_ord  = 0;
      m_pout = '0;
      m_pv   = 0;
      m_ovr  = 0;
    end else begin
      if (bus.flush) begin
        mq.delete();
      end else if (bus.sin_valid) begin
        if (mq.size() == 0) m_ord = bus.dir;
        mq.push_back(bus.sin);
        if (mq.size() == SIZE) begin
          for (int i = 0; i < SIZE; i++) begin
            if (m_ord) w[i] = mq[i];
            else       w[SIZE-1-i] = mq[i];
          end
          done = 1;
          mq.delete();
        end
      end
      if (done) begin
        if (!m_pv || bus.pout_ready) begin
          m_pout = w;
          m_pv   = 1;
        end else begin
          ovr_set = 1;
        end
      end else if (m_pv && bus.pout_ready) begin
        m_pv = 0;
      end
      if (ovr_set)          m_ovr = 1;
      else if (bus.clr_ovr) m_ovr = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dir        = 0;
    bus.sin        = 0;
    bus.sin_valid  = 0;
    bus.flush      = 0;
    bus.clr_ovr    = 0;
    bus.pout_ready = 0;
  endtask

  // Sends bits [from..to] of word w in the order dictated by d.
  task automatic send_range(input logic [SIZE-1:0] w, input bit d, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      bus.dir       = d;
      bus.sin       = d ? w[i] : w[SIZE-1-i];
      bus.sin_valid = 1;
      step();
    end
    bus.sin_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    n_checks++;
    if (bus.pout !== 4'h0 || bus.pout_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got pout=%h pv=%b ovr=%b busy=%b, expected all zero",
               bus.pout, bus.pout_valid, bus.overrun, bus.busy);
    end
  endtask

  task automatic test_msb_first();
    bus.pout_ready = 1;
    send_range(4'b1011, 0, 0, 2);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.pout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_partial: got busy=%b pv=%b, expected busy=1 pv=0", bus.busy, bus.pout_valid);
    end
    send_range(4'b1011, 0, 3, 3);
    n_checks++;
    if (bus.pout !== 4'b1011 || bus.pout_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_word: got pout=%b pv=%b busy=%b, expected 1011 1 0",
               bus.pout, bus.pout_valid, bus.busy);
    end
    step();
    n_checks++;
    if (bus.pout_valid !== 1'b0 || bus.pout !== 4'b1011) begin
      n_fail++;
      $display("FAIL msb_consumed: got pv=%b pout=%b, expected pv=0 pout=1011", bus.pout_valid, bus.pout);
    end
    bus.pout_ready = 0;
  endtask

  task automatic test_lsb_gaps();
    bus.pout_ready = 0;
    send_range(4'b1101, 1, 0, 1);
    bus.dir = 0;
    step();
    step();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.pout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_gap_hold: got busy=%b pv=%b, expected 1 0", bus.busy, bus.pout_valid);
    end
    for (int i = 2; i < 4; i++) begin
      bus.dir       = ~bus.dir;
      bus.sin       = (i == 2) ? 1'b1 : 1'b1;
      bus.sin_valid = 1;
      step();
    end
    bus.sin_valid = 0;
    n_checks++;
    if (bus.pout !== 4'b1101 || bus.pout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_word: got pout=%b pv=%b, expected 1101 1", bus.pout, bus.pout_valid);
    end
    bus.pout_ready = 1;
    step();
    bus.pout_ready = 0;
  endtask

  task automatic test_overrun();
    bus.pout_ready = 0;
    send_range(4'hA, 0, 0, 3);
    send_range(4'h5, 0, 0, 3);
    n_checks++;
    if (bus.pout !== 4'hA || bus.overrun !== 1'b1 || bus.pout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got pout=%h ovr=%b pv=%b, expected A 1 1",
               bus.pout, bus.overrun, bus.pout_valid);
    end
    bus.pout_ready = 1;
    step();
    bus.pout_ready = 0;
    n_checks++;
    if (bus.pout_valid !== 1'b0 || bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_consume: got pv=%b ovr=%b, expected 0 1", bus.pout_valid, bus.overrun);
    end
    bus.clr_ovr = 1;
    step();
    bus.clr_ovr = 0;
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got ovr=%b, expected 0", bus.overrun);
    end
  endtask

  task automatic test_clr_vs_set();
    bus.pout_ready = 0;
    send_range(4'h9, 1, 0, 3);
    send_range(4'h6, 1, 0, 2);
    bus.clr_ovr = 1;
    send_range(4'h6, 1, 3, 3);
    bus.clr_ovr = 0;
    n_checks++;
    if (bus.overrun !== 1'b1 || bus.pout !== 4'h9) begin
      n_fail++;
      $display("FAIL clr_vs_set: got ovr=%b pout=%h, expected 1 9", bus.overrun, bus.pout);
    end
    bus.clr_ovr    = 1;
    bus.pout_ready = 1;
    step();
    bus.clr_ovr    = 0;
    bus.pout_ready = 0;
  endtask

  task automatic test_back_to_back();
    bus.pout_ready = 0;
    send_range(4'h3, 0, 0, 3);
    send_range(4'hC, 0, 0, 2);
    bus.pout_ready = 1;
    send_range(4'hC, 0, 3, 3);
    bus.pout_ready = 0;
    n_checks++;
    if (bus.pout !== 4'hC || bus.pout_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_complete_consume: got pout=%h pv=%b ovr=%b, expected C 1 0",
               bus.pout, bus.pout_valid, bus.overrun);
    end
    bus.pout_ready = 1;
    step();
    bus.pout_ready = 0;
  endtask

  task automatic test_flush();
    bus.pout_ready = 0;
    send_range(4'h3, 0, 0, 3);
    send_range(4'hF, 0, 0, 1);
    bus.flush     = 1;
    bus.sin       = 1;
    bus.sin_valid = 1;
    step();
    bus.flush     = 0;
    bus.sin_valid = 0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.pout !== 4'h3 || bus.pout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: got busy=%b pout=%h pv=%b, expected 0 3 1",
               bus.busy, bus.pout, bus.pout_valid);
    end
    bus.pout_ready = 1;
    step();
    bus.pout_ready = 0;
    send_range(4'h6, 0, 0, 3);
    n_checks++;
    if (bus.pout !== 4'h6 || bus.pout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_next_word: got pout=%h pv=%b, expected 6 1", bus.pout, bus.pout_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.pout_ready = 0;
    send_range(4'hE, 1, 0, 2);
    rst = 1;
    step();
    rst = 0;
    n_checks++;
    if (bus.pout !== 4'h0 || bus.pout_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got pout=%h pv=%b ovr=%b busy=%b, expected all zero",
               bus.pout, bus.pout_valid, bus.overrun, bus.busy);
    end
    send_range(4'h9, 0, 0, 3);
    n_checks++;
    if (bus.pout !== 4'h9 || bus.pout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_clean_word: got pout=%h pv=%b, expected 9 1", bus.pout, bus.pout_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bus.flush      = ($urandom_range(0, 19) == 0);
      bus.clr_ovr    = ($urandom_range(0, 9) == 0);
      bus.sin_valid  = ($urandom_range(0, 9) < 7);
      bus.sin        = 1'($urandom);
      bus.dir        = 1'($urandom);
      bus.pout_ready = 1'($urandom);
      step();
      n_checks++;
      if (bus.pout !== m_pout || bus.pout_valid !== m_pv || bus.overrun !== m_ovr ||
          bus.busy !== (mq.size() != 0)) begin
        n_fail++;
        $display("FAIL random cycle %0d: got pout=%h pv=%b ovr=%b busy=%b, expected pout=%h pv=%b ovr=%b busy=%b",
                 c, bus.pout, bus.pout_valid, bus.overrun, bus.busy,
                 m_pout, m_pv, m_ovr, (mq.size() != 0));
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1;
    idle_inputs();
    test_reset();
    test_msb_first();
    test_lsb_gaps();
    test_overrun();
    test_clr_vs_set();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
